ah_client_dispatch_57_30: RTL and testbench
===========================================

# ah_client_dispatch_57_30

Registered dispatch stage downstream of the 57-bit / 30-client address decoder. It takes each ingress packet field together with its decoded one-hot client select and decode-error flag. It buffers the packet in a 2-entry FIFO and presents it to exactly one of 30 client ports under a per-client valid/ready handshake. Packets that fail decode are dropped and counted; a decode is a failure when the error flag is set, no client is selected, or more than one client is selected.

## Interface
- FIELD_W, 57, ingress packet field width
- NUM_CLIENTS, 30, number of client ports / decoded select width
- IDX_W, 5, client index width (clog2 of NUM_CLIENTS)
- ERR_CNT_W, 16, drop counter width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ingress packet valid
- in_ready  out  1  ingress can accept
- in_pkt_field  in  FIELD_W  packet field, same field the decoder consumed
- in_dec_sel  in  NUM_CLIENTS  decoder output, expected one-hot
- in_dec_err  in  1  decoder error flag
- out_valid  out  NUM_CLIENTS  per-client valid, at most one bit set
- out_ready  in  NUM_CLIENTS  per-client ready
- out_pkt_field  out  FIELD_W  head packet field, shared by all clients
- out_client_idx  out  IDX_W  binary index of the asserted out_valid bit
- err_pulse  out  1  one-cycle pulse per dropped packet
- err_cnt  out  ERR_CNT_W  saturating drop count
- err_cnt_clr  in  1  synchronous clear of err_cnt

## Operation
- **FIFO.** 2-entry FIFO; each entry holds {pkt_field, sel, idx}. Occupancy counter `count` takes values 0..2.
- **Ingress.** `in_ready = (count != 2) && !rst`. A transfer occurs when `in_valid && in_ready`.
- **Classification.** Each accepted packet is classified in the same cycle.
  - Bad if `in_dec_err`, or `in_dec_sel == 0`, or popcount(`in_dec_sel`) > 1.
  - Bad packets are consumed but not written to the FIFO.
  - Good packets are written to the tail with the binary encode of sel as idx.
- **Egress.** `out_valid = (count != 0) ? head.sel : 0`. `out_pkt_field` and `out_client_idx` come from the head entry.
  - Pop when `|(out_valid & out_ready)`.
  - `out_ready` bits of non-selected clients are ignored.
- **Simultaneous push and pop.**
  - At count 1: count stays 1; the new entry becomes head on the next cycle.
  - At count 2: no push is possible because in_ready is low. There is no combinational pass-through.
- **Stability.** While out_valid is set and not popped, head field, sel and idx hold unchanged regardless of ingress activity.
- **Error counter.**
  - `err_pulse` is registered: high for exactly one cycle, the cycle after a bad transfer.
  - `err_cnt` increments by 1 in that same cycle and saturates at 2^ERR_CNT_W−1.
  - When `err_cnt_clr` coincides with an increment, err_cnt becomes 1.
  - `err_cnt_clr` alone sets err_cnt to 0.
- **No reordering.** Good packets leave in arrival order; dropped packets never reach any client.

## Timing
- **Reset** (sampled at clk edge while rst = 1):
  - count = 0, all FIFO entries cleared to 0.
  - out_valid = 0, out_pkt_field = 0, out_client_idx = 0.
  - err_pulse = 0, err_cnt = 0, in_ready = 0.
  - in_ready rises in the first cycle after rst deasserts.
- **Reset mid-operation.** Buffered packets are discarded with no pop and no err_pulse. A transfer presented during the rst cycle is not accepted.
- **Latency.** A good packet accepted at edge N is visible on out_valid from cycle N+1 when the FIFO was empty.
- **Throughput.** 1 packet/cycle sustained when the selected client holds out_ready high.
- **Backpressure.** With no pop, in_ready falls after the second good acceptance. It rises the cycle after the first subsequent pop.
- **Bad packets** still require in_ready, and never change count.

## Test plan
- **Reset.** Hold rst for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, err_cnt = 0 throughout; in_ready = 1 in the cycle after release.
- **Single good packet.**
  - Stimulus: field 57'h1_2345_6789_ABCD, sel = 1<<7; out_ready[7] held 0 for 3 cycles, then 1.
  - Response: out_valid = 1<<7 and out_client_idx = 7 from the next cycle; field stable for 3 cycles; popped on the 4th; out_valid = 0 afterwards.
- **Backpressure and wrap.**
  - Stimulus: 5 good packets to clients 0, 29, 3, 3, 15 with in_valid held 1; all out_ready = 0 for 4 cycles, then all 1.
  - Response: in_ready low after 2 acceptances; all 5 delivered in order, one per cycle once ready; no loss.
- **Decode errors.**
  - Stimulus: packets with dec_err = 1, sel = 0, and sel = 0x3 (two bits), interleaved with a good packet to client 12.
  - Response: 3 err_pulses, err_cnt = 3; only the client-12 packet appears on out_valid.
- **Counter saturation and clear.**
  - Stimulus: force 2^16+2 bad packets.
  - Response: err_cnt = 0xFFFF held.
  - Stimulus: assert err_cnt_clr together with a bad transfer's increment cycle -> err_cnt = 1. Assert clr alone -> err_cnt = 0.
- **Reset mid-flight.** With 2 packets buffered and out_ready = 0, pulse rst for 1 cycle -> out_valid = 0 the next cycle; no stale packet emerges after subsequent out_ready = all 1.

Source files
------------

// File: rtl/ah_client_dispatch_57_30.sv
// ah_client_dispatch_57_30: 2-entry FIFO dispatching decoded packets to one of 30 client ports, dropping and counting bad decodes
module ah_client_dispatch_57_30 #(
  parameter int FIELD_W     = 57,
  parameter int NUM_CLIENTS = 30,
  parameter int IDX_W       = 5,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FIELD_W-1:0]     in_pkt_field,
  input  logic [NUM_CLIENTS-1:0] in_dec_sel,
  input  logic                   in_dec_err,
  output logic [NUM_CLIENTS-1:0] out_valid,
  input  logic [NUM_CLIENTS-1:0] out_ready,
  output logic [FIELD_W-1:0]     out_pkt_field,
  output logic [IDX_W-1:0]       out_client_idx,
  output logic                   err_pulse,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  input  logic                   err_cnt_clr
);
  logic [1:0]             count_q, count_d;
  logic                   hd_q, tl;
  logic [FIELD_W-1:0]     fld_q [2];
  logic [NUM_CLIENTS-1:0] sel_q [2];
  logic [IDX_W-1:0]       idx_q [2];
  logic                   err_pulse_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   good, xfer, push, bad, pop;
  logic [IDX_W-1:0]       enc;
  assign in_ready = count_q != 2'd2 && !rst;
  assign xfer = in_valid && in_ready;
  assign good = !in_dec_err && in_dec_sel != '0 &&
                (in_dec_sel & (in_dec_sel - NUM_CLIENTS'(1))) == '0;
  assign push = xfer && good;
  assign bad = xfer && !good;
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      enc = enc | (in_dec_sel[i] ? IDX_W'(i) : '0);
  end
  assign out_valid = count_q != 2'd0 ? sel_q[hd_q] : '0;
  assign out_pkt_field = fld_q[hd_q];
  assign out_client_idx = idx_q[hd_q];
  assign pop = |(out_valid & out_ready);
  // tail slot sits one past the head only when exactly one entry is live
  assign tl = hd_q ^ (count_q == 2'd1);
  assign count_d = count_q + 2'(push) - 2'(pop);
  assign err_pulse = err_pulse_q;
  assign err_cnt = err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      hd_q        <= 1'b0;
      fld_q       <= '{default: '0};
      sel_q       <= '{default: '0};
      idx_q       <= '{default: '0};
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      count_q     <= count_d;
      hd_q        <= pop ? ~hd_q : hd_q;
      err_pulse_q <= bad;
      err_cnt_q   <= err_cnt_clr ? ERR_CNT_W'(bad) :
                     (bad && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
      if (push) begin
        fld_q[tl] <= in_pkt_field;
        sel_q[tl] <= in_dec_sel;
        idx_q[tl] <= enc;
      end
    end
  end
endmodule

// File: tb/tb_ah_client_dispatch_57_30.sv
// tb_ah_client_dispatch_57_30: randomized and directed checks against a queue-based reference model
module tb_ah_client_dispatch_57_30;
  logic        clk, rst, in_valid, in_ready, in_dec_err, err_pulse, err_cnt_clr;
  logic [56:0] in_pkt_field, out_pkt_field;
  logic [29:0] in_dec_sel, out_valid, out_ready;
  logic [4:0]  out_client_idx;
  logic [15:0] err_cnt;
  typedef struct {logic [56:0] f; int c;} pkt_t;
  pkt_t mq[$];
  bit   m_pulse;
  int   m_cnt, total, bad_n, npulse;
  ah_client_dispatch_57_30 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pkt_field(in_pkt_field), .in_dec_sel(in_dec_sel), .in_dec_err(in_dec_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt_field(out_pkt_field),
    .out_client_idx(out_client_idx), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .err_cnt_clr(err_cnt_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(bit v, logic [56:0] f, logic [29:0] s, bit e);
    in_valid = v;
    in_pkt_field = f;
    in_dec_sel = s;
    in_dec_err = e;
  endtask
  task automatic cycle();
    bit acc, gd, pp;
    int c;
    #1;
    chk("in_ready", in_ready, !rst && mq.size() < 2);
    if (mq.size() != 0) begin
      chk("out_valid", out_valid, 30'(1) << mq[0].c);
      chk("out_idx", out_client_idx, mq[0].c);
      chk("out_field", out_pkt_field, mq[0].f);
    end else chk("out_valid_idle", out_valid, 0);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_cnt", err_cnt, m_cnt);
    if (rst) begin
      mq.delete();
      m_pulse = 0;
      m_cnt = 0;
    end else begin
      acc = in_valid && mq.size() < 2;
      gd = !in_dec_err && $countones(in_dec_sel) == 1;
      pp = mq.size() != 0 && out_ready[mq[0].c];
      c = 0;
      for (int i = 0; i < 30; i++) if (in_dec_sel[i]) c = i;
      if (pp) mq.delete(0);
      if (acc && gd) mq.push_back('{in_pkt_field, c});
      m_pulse = acc && !gd;
      m_cnt = err_cnt_clr ? (m_pulse ? 1 : 0) : (m_pulse && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cl[5];
    int k, n;
    logic [63:0] r64;
    logic [29:0] s;
    total = 0; bad_n = 0; npulse = 0; m_pulse = 0; m_cnt = 0;
    rst = 1; err_cnt_clr = 0; out_ready = '0;
    drive(1, 57'h1, 30'h1, 0);
    @(posedge clk);
    #1;
    mq.delete();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", err_cnt, 0);
      cycle();
    end
    chk("rst_field", out_pkt_field, 0);
    chk("rst_idx", out_client_idx, 0);
    rst = 0;
    drive(0, 0, 0, 0);
    #1 chk("ready_after_rst", in_ready, 1);
    drive(1, 57'h1_2345_6789_ABCD, 30'(1) << 7, 0);
    cycle();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("single_valid", out_valid, 30'(1) << 7);
      chk("single_idx", out_client_idx, 7);
      chk("single_field", out_pkt_field, 57'h1_2345_6789_ABCD);
      cycle();
    end
    out_ready[7] = 1;
    chk("single_valid4", out_valid, 30'(1) << 7);
    cycle();
    out_ready = '0;
    chk("single_gone", out_valid, 0);
    cl = '{0, 29, 3, 3, 15};
    k = 0;
    n = 0;
    while ((k < 5 || mq.size() != 0) && n < 40) begin
      bit acc;
      out_ready = n < 4 ? '0 : '1;
      if (k < 5) drive(1, 57'(64'h0ABC_0000 + k), 30'(1) << cl[k], 0);
      else drive(0, 0, 0, 0);
      acc = k < 5 && mq.size() < 2;
      cycle();
      if (acc) k++;
      if (n == 1) chk("bp_ready_low", in_ready, 0);
      n++;
    end
    chk("bp_all_sent", k, 5);
    chk("bp_drained", mq.size(), 0);
    chk("bp_out_idle", out_valid, 0);
    err_cnt_clr = 1;
    drive(0, 0, 0, 0);
    cycle();
    err_cnt_clr = 0;
    out_ready = '1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1, 57'h11, 30'(1) << 4, 1);
        1: drive(1, 57'h22, 30'h0, 0);
        2: drive(1, 57'h33, 30'h3, 0);
        3: drive(1, 57'h44, 30'(1) << 12, 0);
        default: drive(0, 0, 0, 0);
      endcase
      if (out_valid != 0) chk("dec_only12", out_client_idx, 12);
      cycle();
      npulse += int'(err_pulse);
    end
    chk("dec_pulses", npulse, 3);
    chk("dec_cnt", err_cnt, 3);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 65538; i++) cycle();
    drive(0, 0, 0, 0);
    cycle();
    chk("sat_cnt", err_cnt, 16'hFFFF);
    drive(1, 0, 0, 0);
    err_cnt_clr = 1;
    cycle();
    chk("clr_inc", err_cnt, 1);
    drive(0, 0, 0, 0);
    cycle();
    chk("clr_alone", err_cnt, 0);
    err_cnt_clr = 0;
    out_ready = '0;
    drive(1, 57'h5A5A, 30'(1) << 1, 0);
    cycle();
    drive(1, 57'hA5A5, 30'(1) << 2, 0);
    cycle();
    drive(0, 0, 0, 0);
    chk("mid_two", out_valid, 30'(1) << 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    out_ready = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_no_stale", out_valid, 0);
    end
    for (int i = 0; i < 2000; i++) begin
      r64 = {$urandom, $urandom};
      s = 30'(1) << $urandom_range(0, 29);
      case ($urandom_range(0, 9))
        7: drive($urandom_range(0, 1) == 1, 57'(r64), 30'h0, 0);
        8: drive($urandom_range(0, 1) == 1, 57'(r64), s | (30'(1) << ($urandom_range(0, 28) + (s[29] ? 0 : 1))), 0);
        9: drive($urandom_range(0, 1) == 1, 57'(r64), s, 1);
        default: drive($urandom_range(0, 3) != 0, 57'(r64), s, 0);
      endcase
      out_ready = 30'($urandom);
      if ($urandom_range(0, 2) == 0) out_ready = out_ready | s;
      err_cnt_clr = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 199) == 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
